// File: rtl/prbs_pkg.sv
// Shared PRBS7 definitions: default taps, FSM states, LFSR step and popcount.
// Used by both the generator and the prbs7_checker receive path.
package prbs_pkg;

  localparam int PN_DEF   = 7;
  localparam int TAP1_DEF = 6;
  localparam int TAP2_DEF = 5;
  localparam int MAXW     = 64;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Extend the LFSR by width bits, new bit into the LSB.
  // Bits above width only ever hold shifted-out history and are masked.
  function automatic logic [MAXW-1:0] prbs_next(
    input logic [MAXW-1:0] w,
    input int              width,
    input int              tap1,
    input int              tap2
  );
    logic [MAXW-1:0] d;
    logic [MAXW-1:0] m;
    d = w;
    m = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (i < width) begin
        d    = {d[MAXW-2:0], d[tap1] ^ d[tap2]};
        m[i] = 1'b1;
      end
    end
    return d & m;
  endfunction

  function automatic int unsigned popcount(input logic [MAXW-1:0] w);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAXW; i++) begin
      n = n + int'(w[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/prbs7_checker_popcount.sv
// prbs_popcount: combinational count of set bits in a WIDTH-bit word.
// Ports: word (in, WIDTH), count (out, $clog2(WIDTH+1)).
module prbs_popcount #(
  parameter  int WIDTH = 24,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] word,
  output logic [CW-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(word[i]);
    end
  end

endmodule

// File: rtl/prbs7_checker.sv
// prbs7_checker: self-synchronising PRBS7 receive checker with bit-error count.
// Ports: clk, rst_n (sync, active-low), data_in/data_vld, err_clr; locked, err_word, err_bits, err_cnt.
module prbs7_checker
  import prbs_pkg::*;
#(
  parameter  int WIDTH      = 24,
  parameter  int PN         = PN_DEF,
  parameter  int TAP1       = TAP1_DEF,
  parameter  int TAP2       = TAP2_DEF,
  parameter  int LOCK_CNT   = 4,
  parameter  int UNLOCK_ERR = 3,
  parameter  int ERRW       = 16,
  localparam int CW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_vld,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_word,
  output logic [CW-1:0]    err_bits,
  output logic [ERRW-1:0]  err_cnt
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(UNLOCK_ERR + 1);
  localparam int SW = ((ERRW > CW) ? ERRW : CW) + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'((64'd1 << ERRW) - 64'd1);
  // A word narrower than the LFSR order cannot seed a prediction.
  localparam bit PRED_OK = (WIDTH >= PN);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] ref_q;
  logic             have_prev_q;
  logic [MW-1:0]    match_q;
  logic [EW-1:0]    err_run_q;
  logic             err_word_q;
  logic [CW-1:0]    err_bits_q;
  logic [ERRW-1:0]  err_cnt_q;

  logic [MAXW-1:0]  nx_prev_w;
  logic [MAXW-1:0]  nx_data_w;
  logic [MAXW-1:0]  nx_ref_w;
  logic [WIDTH-1:0] cmp_word;
  logic [WIDTH-1:0] mism;
  logic [CW-1:0]    pc;
  logic             hunt_cmp;
  logic             chk;
  logic             hit;
  logic             lock_go;
  logic             err_hit;
  logic             unlock_go;
  logic [SW-1:0]    sum;
  logic [ERRW-1:0]  cnt_d;

  assign nx_prev_w = prbs_next(MAXW'(prev_q), WIDTH, TAP1, TAP2);
  assign nx_data_w = prbs_next(MAXW'(data_in), WIDTH, TAP1, TAP2);
  assign nx_ref_w  = prbs_next(MAXW'(ref_q), WIDTH, TAP1, TAP2);

  // HUNT predicts from the last received word, LOCKED from the free-running ref.
  assign cmp_word = (state_q == LOCKED) ? ref_q : nx_prev_w[WIDTH-1:0];
  assign mism     = data_in ^ cmp_word;

  prbs_popcount #(
    .WIDTH (WIDTH)
  ) u_pc (
    .word  (mism),
    .count (pc)
  );

  assign hunt_cmp  = data_vld && (state_q == HUNT) && have_prev_q;
  assign chk       = data_vld && (state_q == LOCKED);
  // All-zero is the LFSR lock-up state, never evidence of sync.
  assign hit       = hunt_cmp && (mism == '0) && (|data_in) && PRED_OK;
  assign lock_go   = hit && (match_q == MW'(LOCK_CNT - 1));
  assign err_hit   = chk && (|mism);
  assign unlock_go = err_hit && (err_run_q == EW'(UNLOCK_ERR - 1));

  // Clear-then-add; width SW keeps the carry so the clamp is exact.
  always_comb begin
    sum = err_clr ? '0 : SW'(err_cnt_q);
    if (chk) begin
      sum = sum + SW'(pc);
    end
    cnt_d = (sum > CNT_MAX) ? CNT_MAX[ERRW-1:0] : sum[ERRW-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      lock_go:   state_d = LOCKED;
      unlock_go: state_d = HUNT;
      default:   state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      prev_q      <= '0;
      ref_q       <= '0;
      have_prev_q <= 1'b0;
      match_q     <= '0;
      err_run_q   <= '0;
      err_word_q  <= 1'b0;
      err_bits_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      err_word_q <= err_hit;
      if (hunt_cmp || chk) begin
        err_bits_q <= pc;
      end
      if (err_clr || chk) begin
        err_cnt_q <= cnt_d;
      end
      if (data_vld && (state_q == HUNT)) begin
        prev_q      <= data_in;
        have_prev_q <= 1'b1;
      end
      if (hunt_cmp) begin
        if (lock_go || !hit) begin
          match_q <= '0;
        end else begin
          match_q <= match_q + MW'(1);
        end
      end
      if (lock_go) begin
        ref_q     <= nx_data_w[WIDTH-1:0];
        err_run_q <= '0;
      end else if (chk) begin
        ref_q <= nx_ref_w[WIDTH-1:0];
        if (unlock_go || !err_hit) begin
          err_run_q <= '0;
        end else begin
          err_run_q <= err_run_q + EW'(1);
        end
      end
      if (unlock_go) begin
        have_prev_q <= 1'b0;
        match_q     <= '0;
      end
    end
  end

  assign locked   = (state_q == LOCKED);
  assign err_word = err_word_q;
  assign err_bits = err_bits_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Bench for prbs7_checker: spec vector table, directed corner sequences,
// and randomized traffic against a bit-stream reference model.
module tb_prbs7_checker;

  localparam int W = 24;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  d;
  logic          v;
  logic          c;
  logic          o_locked, o_word;
  logic [4:0]    o_bits;
  logic [15:0]   o_cnt;
  logic          o2_locked, o2_word;
  logic [4:0]    o2_bits;
  logic [3:0]    o2_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  prbs7_checker u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (d),
    .data_vld (v),
    .err_clr  (c),
    .locked   (o_locked),
    .err_word (o_word),
    .err_bits (o_bits),
    .err_cnt  (o_cnt)
  );

  prbs7_checker #(
    .ERRW (4)
  ) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (d),
    .data_vld (v),
    .err_clr  (c),
    .locked   (o2_locked),
    .err_word (o2_word),
    .err_bits (o2_bits),
    .err_cnt  (o2_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator as a bit stream: s[n] = s[n-7] ^ s[n-6], word = last 24 bits.
  function automatic logic [W-1:0] gen_next(input logic [W-1:0] w);
    bit s[$];
    logic [W-1:0] r;
    for (int k = W - 1; k >= 0; k--) s.push_back(w[k]);
    for (int k = 0; k < W; k++) begin
      int n;
      n = s.size();
      s.push_back(s[n-7] ^ s[n-6]);
    end
    for (int k = 0; k < W; k++) r[k] = s[s.size() - 1 - k];
    return r;
  endfunction

  // Reference model state
  bit           m_locked, m_have, m_word;
  logic [W-1:0] m_prev, m_ref;
  int           m_mrun, m_erun, m_bits, m_cnt, m_cnt4;

  task automatic model_step(input logic [W-1:0] dd, input bit vv,
                            input bit cc, input bit rn);
    int pc;
    bit chkd;
    pc = 0;
    chkd = 0;
    if (!rn) begin
      m_locked = 0; m_have = 0; m_word = 0; m_prev = '0; m_ref = '0;
      m_mrun = 0; m_erun = 0; m_bits = 0; m_cnt = 0; m_cnt4 = 0;
      return;
    end
    m_word = 0;
    if (vv) begin
      if (!m_locked) begin
        if (m_have) begin
          pc = $countones(dd ^ gen_next(m_prev));
          m_bits = pc;
          if (pc == 0 && dd != 0) m_mrun++;
          else m_mrun = 0;
          if (m_mrun == 4) begin
            m_locked = 1; m_ref = gen_next(dd); m_erun = 0; m_mrun = 0;
          end
        end
        m_have = 1;
        m_prev = dd;
      end else begin
        chkd = 1;
        pc = $countones(dd ^ m_ref);
        m_ref = gen_next(m_ref);
        m_bits = pc;
        m_word = (pc != 0);
        if (pc != 0) m_erun++;
        else m_erun = 0;
        if (m_erun == 3) begin
          m_locked = 0; m_have = 0; m_mrun = 0; m_erun = 0;
        end
      end
    end
    if (cc) begin
      m_cnt  = chkd ? pc : 0;
      m_cnt4 = (chkd && pc < 15) ? pc : (chkd ? 15 : 0);
    end else if (chkd) begin
      m_cnt  = (m_cnt + pc > 65535) ? 65535 : m_cnt + pc;
      m_cnt4 = (m_cnt4 + pc > 15) ? 15 : m_cnt4 + pc;
    end
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic mcheck(input string nm);
    chk({nm, "_locked"}, o_locked, m_locked);
    chk({nm, "_word"}, o_word, m_word);
    chk({nm, "_bits"}, o_bits, m_bits);
    chk({nm, "_cnt"}, o_cnt, m_cnt);
    chk({nm, "_cnt4"}, o2_cnt, m_cnt4);
  endtask

  task automatic cyc(input logic [W-1:0] dd, input bit vv, input bit cc,
                     input string nm);
    d = dd; v = vv; c = cc;
    @(posedge clk);
    #1;
    model_step(dd, vv, cc, rst_n);
    mcheck(nm);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc('0, 1'b0, 1'b0, "rst");
    cyc('0, 1'b0, 1'b0, "rst");
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [W-1:0] data;
    bit           e_locked;
    bit           e_word;
    int           e_bits;
    int           e_cnt;
  } vec_t;

  vec_t         tbl[12];
  logic [W-1:0] gw;
  logic [W-1:0] w;
  int           nlock;

  initial begin
    rst_n = 1'b0; d = '0; v = 1'b0; c = 1'b0;
    do_reset();
    chk("reset_locked", o_locked, 0);
    chk("reset_bits", o_bits, 0);
    chk("reset_cnt", o_cnt, 0);

    // Lock from seed, then a single bit-0 error on word 7.
    gw = 24'h000001;
    for (int i = 0; i < 12; i++) begin
      tbl[i].data     = (i == 7) ? (gw ^ 24'h1) : gw;
      tbl[i].e_locked = (i >= 4);
      tbl[i].e_word   = (i == 7);
      tbl[i].e_bits   = (i == 7) ? 1 : 0;
      tbl[i].e_cnt    = (i >= 7) ? 1 : 0;
      gw = gen_next(gw);
    end
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].data, 1'b1, 1'b0, "t1m");
      chk($sformatf("t1_locked[%0d]", i), o_locked, tbl[i].e_locked);
      chk($sformatf("t1_word[%0d]", i), o_word, tbl[i].e_word);
      chk($sformatf("t1_bits[%0d]", i), o_bits, tbl[i].e_bits);
      chk($sformatf("t1_cnt[%0d]", i), o_cnt, tbl[i].e_cnt);
    end

    // Clear, then a long clean run.
    cyc('0, 1'b0, 1'b1, "t1clr");
    chk("t1_clr", o_cnt, 0);
    for (int i = 0; i < 1000; i++) begin
      cyc(gw, 1'b1, 1'b0, "t1run");
      gw = gen_next(gw);
    end
    chk("t1_long_cnt", o_cnt, 0);
    chk("t1_long_locked", o_locked, 1);

    // Three fully inverted words force unlock; then re-lock.
    for (int i = 0; i < 3; i++) begin
      cyc(gw ^ 24'hFFFFFF, 1'b1, 1'b0, "t3");
      gw = gen_next(gw);
      chk($sformatf("t3_bits[%0d]", i), o_bits, 24);
    end
    chk("t3_cnt", o_cnt, 72);
    chk("t3_unlocked", o_locked, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(gw, 1'b1, 1'b0, "t3re");
      gw = gen_next(gw);
      chk($sformatf("t3_relock[%0d]", i), o_locked, (i == 4));
    end

    // All-zero input never locks.
    do_reset();
    nlock = 0;
    for (int i = 0; i < 50; i++) begin
      cyc('0, 1'b1, 1'b0, "t4");
      if (o_locked) nlock++;
    end
    chk("t4_never_locked", nlock, 0);
    chk("t4_cnt", o_cnt, 0);

    // Saturation of the 4-bit counter and clear-with-add.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(gw, 1'b1, 1'b0, "t5lk");
      gw = gen_next(gw);
    end
    for (int i = 0; i < 20; i++) begin
      w = gw ^ (24'h1 << (i % W));
      cyc(w, 1'b1, 1'b0, "t5e");
      gw = gen_next(gw);
      cyc(gw, 1'b1, 1'b0, "t5c");
      gw = gen_next(gw);
    end
    chk("t5_sat4", o2_cnt, 15);
    chk("t5_cnt16", o_cnt, 20);
    chk("t5_still_locked", o_locked, 1);
    cyc(gw ^ 24'h000003, 1'b1, 1'b1, "t5clr");
    gw = gen_next(gw);
    chk("t5_clr_add4", o2_cnt, 2);
    chk("t5_clr_add16", o_cnt, 2);

    // Random gaps, sparse errors, occasional clears, mid-run reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit vv;
      bit cc;
      vv = ($urandom % 2) == 1;
      cc = ($urandom % 64) == 0;
      w  = gw;
      if (($urandom % 20) == 0) w = w ^ (24'h1 << $urandom_range(0, W - 1));
      if (i == 1500) begin
        rst_n = 1'b0;
        cyc(w, vv, cc, "t6rst");
        rst_n = 1'b1;
        chk("t6_rst_locked", o_locked, 0);
        chk("t6_rst_word", o_word, 0);
        chk("t6_rst_bits", o_bits, 0);
        chk("t6_rst_cnt", o_cnt, 0);
      end else begin
        cyc(w, vv, cc, "t6");
      end
      if (vv) gw = gen_next(gw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
